// File: rtl/spi_seq.sv
// spi_seq: byte sequencer sitting in front of spi_controller.
//
// The CPU queues bytes into an 8-entry TX FIFO through TXDATA. For every
// byte the sequencer acts as a bus master on spi_controller: it loads DATA,
// raises tx_start, polls STATUS until the byte has finished, stores the
// received byte in the RX FIFO and drops tx_start again. The CPU drains
// received bytes through RXDATA.
//
// Register map (offsets from ADDR):
//   +0  STATUS  RO  [3:0] tx_count, [7:4] rx_count, [8] busy,
//                   [9] tx_ovf (sticky), [10] done (sticky);
//                   any write clears tx_ovf and done
//   +4  CTRL    RW  [0] en, [1] cs, [2] irq_en, [31:3] clkdiv
//   +8  TXDATA  WO  wdata[7:0] pushed when wmask[0] is set
//   +12 RXDATA  RO  head of RX FIFO, popped by the read
//
// Build option: define SPI_SEQ_IRQ_EN to get a registered completion
// interrupt (irq = irq_en & done). Without it irq is tied low and CTRL
// bit2 always reads 0.

// Small FIFO with a combinational head. The head has to be visible in the
// same cycle as the pop (RXDATA returns and pops together, LOAD drives the
// head onto the bus while popping), so the storage is read asynchronously.
// Callers only assert push/pop when the operation is legal.
module spi_seq_fifo #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Storage write; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg + CW'(push) - CW'(pop);
        if (push) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

endmodule

module spi_seq #(
    parameter logic [31:0] ADDR       = 32'he000,
    parameter logic [31:0] SPI_ADDR   = 32'hd000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    // CPU slave bus
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        wen,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        active,
    // master bus towards spi_controller
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wmask,
    output logic        m_wen,
    output logic        m_ren,
    input  logic [31:0] m_rdata,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [31:0] SPI_STATUS  = SPI_ADDR;
    localparam logic [31:0] SPI_CONTROL = SPI_ADDR + 32'd4;
    localparam logic [31:0] SPI_DATA    = SPI_ADDR + 32'd8;

`ifdef SPI_SEQ_IRQ_EN
    localparam logic [31:0] CTRL_WR_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] CTRL_WR_MASK = 32'hFFFF_FFFB;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_LOAD,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_STOP,
        S_GAP
    } state_t;

    state_t state_reg;
    state_t state_next;

    // register file
    logic [31:0] ctrl_reg;
    logic [31:0] ctrl_next;
    logic        ctrl_dirty_reg;
    logic        tx_ovf_reg;
    logic        done_reg;
    logic        done_next;
    // SPI CONTROL image (tx_start bit clear) last written by SYNC; START and
    // STOP reuse it so a CTRL write mid-byte cannot leak into spi_controller
    logic [31:0] spi_ctrl_reg;
    logic [31:0] spi_ctrl_fresh;

    // address decode
    logic hit_status;
    logic hit_ctrl;
    logic hit_txdata;
    logic hit_rxdata;
    logic ctrl_wr;
    logic status_wr;

    // FIFO plumbing
    logic          tx_push_req;
    logic          tx_push;
    logic          tx_drop;
    logic          tx_pop;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] tx_count_after;
    logic          tx_empty;
    logic          tx_full;
    logic          rx_push;
    logic          rx_pop;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count;
    logic          rx_empty;
    logic          rx_full;

    logic        busy;
    logic        done_set;
    logic [3:0]  tx_cnt4;
    logic [3:0]  rx_cnt4;
    logic [31:0] status_word;
    logic        unused_bits;

    assign hit_status = (addr == ADDR);
    assign hit_ctrl   = (addr == ADDR + 32'd4);
    assign hit_txdata = (addr == ADDR + 32'd8);
    assign hit_rxdata = (addr == ADDR + 32'd12);
    assign active     = hit_status | hit_ctrl | hit_txdata | hit_rxdata;
    assign ready      = 1'b1;

    assign ctrl_wr    = wen & hit_ctrl;
    assign status_wr  = wen & hit_status;

    // A push into a full TX FIFO still lands if a pop frees a slot in the same cycle
    assign tx_push_req = wen & hit_txdata & wmask[0];
    assign tx_pop      = (state_reg == S_LOAD) & ~tx_empty;
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    assign tx_drop     = tx_push_req & ~tx_push;

    assign rx_pop  = ren & hit_rxdata & ~rx_empty;
    assign rx_push = (state_reg == S_CAPTURE) & (~rx_full | rx_pop);

    assign tx_count_after = tx_count + CW'(tx_push) - CW'(tx_pop);
    assign done_set       = (state_reg == S_CAPTURE) & (tx_count_after == '0);

    assign busy = (state_reg != S_IDLE) && (state_reg != S_SYNC);

    assign tx_cnt4     = 4'(tx_count);
    assign rx_cnt4     = 4'(rx_count);
    assign status_word = {21'b0, done_reg, tx_ovf_reg, busy, rx_cnt4, tx_cnt4};

    // clkdiv lands in SPI CONTROL[31:2] as {1'b0, clkdiv}, cs in bit1
    assign spi_ctrl_fresh = {1'b0, ctrl_reg[31:3], ctrl_reg[1], 1'b0};

    // Only the master read-data fields the FSM looks at are consumed
    assign unused_bits = ^{m_rdata[31:16], m_rdata[7:2]};

    spi_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_push),
        .push_data (wdata[7:0]),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    spi_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rx_push),
        .push_data (m_rdata[15:8]),
        .pop       (rx_pop),
        .head      (rx_head),
        .count     (rx_count),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    // Byte-lane merge for CTRL writes
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ctrl_lane
            assign ctrl_next[gi*8 +: 8] = (ctrl_wr && wmask[gi])
                                        ? (wdata[gi*8 +: 8] & CTRL_WR_MASK[gi*8 +: 8])
                                        : ctrl_reg[gi*8 +: 8];
        end
    endgenerate

    // Sticky done: a completion in the same cycle as a STATUS write wins
    always_comb begin
        done_next = done_reg;
        if (status_wr) begin
            done_next = 1'b0;
        end
        if (done_set) begin
            done_next = 1'b1;
        end
    end

    // Control/status registers and the SPI CONTROL image
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg       <= '0;
            ctrl_dirty_reg <= 1'b1;
            tx_ovf_reg     <= 1'b0;
            done_reg       <= 1'b0;
            spi_ctrl_reg   <= '0;
        end else begin
            ctrl_reg <= ctrl_next;
            done_reg <= done_next;
            // a CTRL write landing during SYNC keeps the flag so it is synced again
            if (ctrl_wr) begin
                ctrl_dirty_reg <= 1'b1;
            end else if (state_reg == S_SYNC) begin
                ctrl_dirty_reg <= 1'b0;
            end
            if (tx_drop) begin
                tx_ovf_reg <= 1'b1;
            end else if (status_wr) begin
                tx_ovf_reg <= 1'b0;
            end
            if (state_reg == S_SYNC) begin
                spi_ctrl_reg <= spi_ctrl_fresh;
            end
        end
    end

`ifdef SPI_SEQ_IRQ_EN
    logic irq_reg;

    // Registered completion interrupt, held until STATUS is written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= ctrl_next[2] & done_next;
        end
    end

    assign irq = irq_reg;
`else
    assign irq = 1'b0;
`endif

    // CPU read mux; RXDATA of an empty FIFO reads as zero
    always_comb begin
        rdata = '0;
        if (hit_status) begin
            rdata = status_word;
        end else if (hit_ctrl) begin
            rdata = ctrl_reg;
        end else if (hit_rxdata && !rx_empty) begin
            rdata = {24'b0, rx_head};
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Sequencer next state and master-bus drive; idle master bus is all zero
    always_comb begin
        state_next = state_reg;
        m_addr     = '0;
        m_wdata    = '0;
        m_wmask    = '0;
        m_wen      = 1'b0;
        m_ren      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (ctrl_dirty_reg) begin
                    state_next = S_SYNC;
                end else if (ctrl_reg[0] && !tx_empty && !rx_full) begin
                    state_next = S_LOAD;
                end
            end
            S_SYNC: begin
                m_addr     = SPI_CONTROL;
                m_wdata    = spi_ctrl_fresh;
                m_wmask    = 4'hF;
                m_wen      = 1'b1;
                state_next = S_IDLE;
            end
            S_LOAD: begin
                m_addr     = SPI_DATA;
                m_wdata    = {24'b0, tx_head};
                m_wmask    = 4'h1;
                m_wen      = 1'b1;
                state_next = S_START;
            end
            S_START: begin
                m_addr     = SPI_CONTROL;
                m_wdata    = spi_ctrl_reg | 32'h1;
                m_wmask    = 4'hF;
                m_wen      = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                m_addr = SPI_STATUS;
                m_ren  = 1'b1;
                if (m_rdata[0]) begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                m_addr     = SPI_DATA;
                m_ren      = 1'b1;
                state_next = S_STOP;
            end
            S_STOP: begin
                m_addr     = SPI_CONTROL;
                m_wdata    = spi_ctrl_reg;
                m_wmask    = 4'hF;
                m_wen      = 1'b1;
                state_next = S_GAP;
            end
            S_GAP: begin
                m_addr = SPI_STATUS;
                m_ren  = 1'b1;
                if (m_rdata[1:0] == 2'b00) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_seq.sv
// Bench for spi_seq: a behavioural spi_controller in loopback answers the
// master bus; expected RX bytes go into a scoreboard queue when pushed and
// are compared when read back from RXDATA.
`timescale 1ns/1ps
module tb_spi_seq;

    localparam logic [31:0] A_STATUS = 32'he000;
    localparam logic [31:0] A_CTRL   = 32'he004;
    localparam logic [31:0] A_TX     = 32'he008;
    localparam logic [31:0] A_RX     = 32'he00c;
    localparam logic [31:0] S_STAT   = 32'hd000;
    localparam logic [31:0] S_CTRL   = 32'hd004;
    localparam logic [31:0] S_DATA   = 32'hd008;
    localparam int          SPI_LAT  = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [31:0] rdata;
    logic        ready;
    logic        active;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    logic        m_wen;
    logic        m_ren;
    logic [31:0] m_rdata;
    logic        irq;

    int total = 0;
    int bad = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    spi_seq dut (
        .clk(clk), .rst_n(rst_n),
        .addr(addr), .wdata(wdata), .wmask(wmask), .wen(wen), .ren(ren),
        .rdata(rdata), .ready(ready), .active(active),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
        .m_wen(m_wen), .m_ren(m_ren), .m_rdata(m_rdata), .irq(irq)
    );

    // behavioural spi_controller, loopback: rx byte = tx byte
    logic [31:0] spi_ctrl = '0;
    logic [7:0]  spi_tx = '0;
    logic [7:0]  spi_rx = '0;
    logic        spi_busy = 1'b0;
    logic        spi_fin = 1'b0;
    int          spi_cnt = 0;

    always @(posedge clk) begin
        if (m_wen && m_addr == S_CTRL) spi_ctrl <= m_wdata;
        if (m_wen && m_addr == S_DATA && m_wmask[0]) spi_tx <= m_wdata[7:0];
        if (spi_busy) begin
            if (spi_cnt == 0) begin
                spi_busy <= 1'b0;
                spi_fin  <= 1'b1;
                spi_rx   <= spi_tx;
            end else begin
                spi_cnt <= spi_cnt - 1;
            end
        end else if (spi_ctrl[0] && !spi_fin) begin
            spi_busy <= 1'b1;
            spi_cnt  <= SPI_LAT;
        end else if (!spi_ctrl[0] && spi_fin) begin
            spi_fin <= 1'b0;
        end
    end

    always_comb begin
        m_rdata = '0;
        case (m_addr)
            S_STAT:  m_rdata = {30'b0, spi_busy, spi_fin};
            S_CTRL:  m_rdata = spi_ctrl;
            S_DATA:  m_rdata = {16'b0, spi_rx, spi_tx};
            default: m_rdata = '0;
        endcase
    end

    // bus monitors
    int   excl_bad = 0;
    int   irq_rises = 0;
    logic irq_q = 1'b0;
    always @(posedge clk) begin
        if (m_wen && m_ren) excl_bad <= excl_bad + 1;
        irq_q <= irq;
        if (irq && !irq_q) irq_rises <= irq_rises + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        addr = a; wdata = d; wmask = m; wen = 1'b1;
        @(posedge clk); #1;
        wen = 1'b0; wmask = '0; addr = '0; wdata = '0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; ren = 1'b1;
        #1 d = rdata;
        @(posedge clk); #1;
        ren = 1'b0; addr = '0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus_wr(A_TX, {24'b0, b}, 4'h1);
        sb.push_back(b);
    endtask

    task automatic drain(input int n);
        logic [31:0] d;
        logic [7:0]  e;
        for (int i = 0; i < n; i++) begin
            e = 8'h00;
            if (sb.size() > 0) e = sb.pop_front();
            bus_rd(A_RX, d);
            check_val($sformatf("rxdata[%0d]", i), d, {24'b0, e});
        end
    endtask

    task automatic wait_stat(input logic [31:0] mask, input logic [31:0] val, input string tag);
        logic [31:0] s;
        int n;
        n = 0;
        bus_rd(A_STATUS, s);
        while (((s & mask) != val) && n < 400) begin
            bus_rd(A_STATUS, s);
            n++;
        end
        check_val(tag, s & mask, val);
    endtask

    task automatic wait_spi(input int b, input logic v, input string tag);
        int n;
        n = 0;
        while (spi_ctrl[b] !== v && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {31'b0, spi_ctrl[b]}, {31'b0, v});
    endtask

    // first master access after reset must be SYNC writing 0 to SPI CONTROL
    task automatic wait_access(input string tag);
        int n;
        n = 0;
        while (!(m_wen || m_ren) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_kind"}, {30'b0, m_wen, m_ren}, 32'h2);
        check_val({tag, "_addr"}, m_addr, S_CTRL);
        check_val({tag, "_data"}, m_wdata, 32'h0);
        check_val({tag, "_mask"}, {28'b0, m_wmask}, 32'hF);
    endtask

    initial begin
        logic [31:0] s;
        int n;
        int rise_base;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check_val("rst_mbus", {26'b0, m_wen, m_ren, m_wmask}, 32'h0);
        check_val("rst_maddr", m_addr | m_wdata, 32'h0);
        check_val("rst_irq", {31'b0, irq}, 32'h0);
        check_val("ready", {31'b0, ready}, 32'h1);
        addr = A_STATUS; #1;
        check_val("rst_status", rdata, 32'h0);
        check_val("active_hit", {31'b0, active}, 32'h1);
        addr = A_CTRL; #1;
        check_val("rst_ctrl", rdata, 32'h0);
        addr = 32'he010; #1;
        check_val("active_miss", {31'b0, active}, 32'h0);
        check_val("rdata_miss", rdata, 32'h0);
        addr = '0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_access("first");

        // ---- loopback single byte, push-to-LOAD latency ----
        bus_wr(A_CTRL, 32'h9, 4'hF);
        repeat (4) @(negedge clk);
        check_val("sync_clkdiv", spi_ctrl, 32'h4);
        @(negedge clk);
        addr = A_TX; wdata = 32'hA5; wmask = 4'h1; wen = 1'b1;
        sb.push_back(8'hA5);
        @(posedge clk); #1;
        wen = 1'b0; wmask = '0; addr = '0; wdata = '0;
        check_val("lat_edge1", {31'b0, m_wen}, 32'h0);
        @(posedge clk); #1;
        check_val("lat_wen", {31'b0, m_wen}, 32'h1);
        check_val("lat_addr", m_addr, S_DATA);
        check_val("lat_data", m_wdata, 32'hA5);
        check_val("lat_mask", {28'b0, m_wmask}, 32'h1);
        wait_stat(32'h4FF, 32'h410, "a5_done");
        drain(1);
        bus_rd(A_RX, s);
        check_val("rx_empty_rd", s, 32'h0);
        bus_rd(A_STATUS, s);
        check_val("rx_empty_cnt", s & 32'hFF, 32'h0);

        // ---- overflow with en=0, then burst of 8 ----
        bus_wr(A_CTRL, 32'h8, 4'hF);
        bus_wr(A_STATUS, 32'h0, 4'hF);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) push_byte(8'(i));
        bus_wr(A_TX, 32'h08, 4'h1);
        bus_rd(A_STATUS, s);
        check_val("tx_ovf", {31'b0, s[9]}, 32'h1);
        check_val("tx_cnt8", {28'b0, s[3:0]}, 32'h8);
        check_val("idle_en0", {31'b0, s[8]}, 32'h0);
        bus_wr(A_STATUS, 32'h0, 4'hF);
        bus_rd(A_STATUS, s);
        check_val("sticky_clr", {30'b0, s[10:9]}, 32'h0);
        bus_wr(A_CTRL, 32'h9, 4'hF);
        wait_stat(32'h4FF, 32'h480, "burst8_done");
        drain(8);

        // ---- RX full stalls the sequencer ----
        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
        wait_stat(32'h1FF, 32'h080, "rx_fill");
        push_byte(8'h18);
        repeat (30) @(negedge clk);
        bus_rd(A_STATUS, s);
        check_val("rx_full_stall", s & 32'h1FF, 32'h081);
        drain(1);
        wait_stat(32'h1FF, 32'h080, "resume");
        drain(8);

        // ---- CTRL cs change during WAIT is deferred ----
        push_byte(8'h5A);
        wait_spi(0, 1'b1, "e_start");
        bus_wr(A_CTRL, 32'hB, 4'hF);
        wait_spi(0, 1'b0, "e_stop");
        check_val("cs_hold", spi_ctrl, 32'h4);
        n = 0;
        while (spi_ctrl !== 32'h6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("cs_sync", spi_ctrl, 32'h6);
        drain(1);

        // ---- completion interrupt over a 2-byte burst ----
        bus_wr(A_STATUS, 32'h0, 4'hF);
        bus_wr(A_CTRL, 32'hF, 4'hF);
        rise_base = irq_rises;
        push_byte(8'hC3);
        push_byte(8'h3C);
        wait_stat(32'h4FF, 32'h420, "burst2_done");
        bus_rd(A_CTRL, s);
`ifdef SPI_SEQ_IRQ_EN
        check_val("ctrl_rb", s, 32'hF);
        check_val("irq_set", {31'b0, irq}, 32'h1);
        check_val("irq_rises", 32'(irq_rises - rise_base), 32'h1);
`else
        check_val("ctrl_rb", s, 32'hB);
        check_val("irq_off", {31'b0, irq}, 32'h0);
        check_val("irq_rises", 32'(irq_rises - rise_base), 32'h0);
`endif
        bus_wr(A_STATUS, 32'h0, 4'hF);
        check_val("irq_clr", {31'b0, irq}, 32'h0);
        drain(2);

        // ---- reset in the middle of WAIT ----
        push_byte(8'h77);
        wait_spi(0, 1'b1, "g_start");
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_mbus", {26'b0, m_wen, m_ren, m_wmask}, 32'h0);
        check_val("midrst_maddr", m_addr | m_wdata, 32'h0);
        addr = A_STATUS; #1;
        check_val("midrst_status", rdata, 32'h0);
        addr = '0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_access("rerun");
        repeat (3) @(negedge clk);
        check_val("stale_start", spi_ctrl, 32'h0);
        bus_rd(A_STATUS, s);
        check_val("post_rst_status", s, 32'h0);

        check_val("m_excl", 32'(excl_bad), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
